// File: rtl/fetch_controller_if.sv
// Fetch-stage bus bundle: instruction-memory handshake, decode handoff and redirect inputs.
// The master modport is the controller side; slave is the memory/decode environment.
interface fetch_controller_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        fetch_fault;

  modport master (
    output imem_req, imem_addr, instr_valid, instruction, pc_current, pc_next, fetch_fault,
    input  imem_ready, imem_rdata, stall, redirect, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instruction, pc_current, pc_next, fetch_fault,
    output imem_ready, imem_rdata, stall, redirect, redirect_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC ownership, imem request/ready handshake, decode hold, redirects.
// Optional FETCH_TIMEOUT_EN macro enables the consecutive-unready-cycle fault counter.
module fetch_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic clk,
  input  logic reset,
  fetch_controller_if.master bus
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  if (RESET_PC[1:0] != 2'b00 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
    $error("fetch_controller: RESET_PC must be word aligned and TIMEOUT in 1..255");
  end

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        timeout;

`ifdef FETCH_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;

  // Counts consecutive unready FETCH cycles; any exit from FETCH or completion clears it.
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == FETCH && !bus.redirect && !bus.imem_ready)
      wait_cnt_d = wait_cnt_q + 8'd1;
  end

  assign timeout = (state_q == FETCH) && !bus.imem_ready &&
                   (wait_cnt_q == 8'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH, HOLD: begin
        // Redirect wins over any same-cycle completion or accept.
        if (bus.redirect) begin
          if (bus.redirect_pc[1:0] != 2'b00) begin
            state_d = FAULT;
          end else begin
            state_d = FETCH;
            pc_d    = bus.redirect_pc;
          end
        end else if (state_q == FETCH) begin
          if (timeout) begin
            state_d = FAULT;
          end else if (bus.imem_ready) begin
            instr_d = bus.imem_rdata;
            state_d = HOLD;
          end
        end else if (!bus.stall) begin
          pc_d    = pc_q + 32'd4;
          state_d = FETCH;
        end
      end
      default: state_d = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign bus.imem_req    = (state_q == FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.pc_current  = pc_q;
  assign bus.pc_next     = pc_q + 32'd4;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instruction = instr_q;
  assign bus.fetch_fault = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller: table of per-cycle stimulus/expectations plus corner sequences.
module tb_fetch_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_controller_if bus ();

  fetch_controller #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        rdy;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_pc;
    logic        e_vld;
    logic [31:0] e_instr;
    logic        e_fault;
  } vec_t;

  function automatic vec_t mk(logic rst_n, logic rdy, logic [31:0] rdata, logic stall,
                              logic redir, logic [31:0] rpc, logic e_req, logic [31:0] e_pc,
                              logic e_vld, logic [31:0] e_instr, logic e_fault);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.rdata = rdata; v.stall = stall;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_pc = e_pc;
    v.e_vld = e_vld; v.e_instr = e_instr; v.e_fault = e_fault;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive inputs, take one clock edge, then compare the post-edge outputs.
  task automatic step(input vec_t v, input string nm);
    logic [31:0] exp_nx;
    reset           = v.rst_n;
    bus.imem_ready  = v.rdy;
    bus.imem_rdata  = v.rdata;
    bus.stall       = v.stall;
    bus.redirect    = v.redir;
    bus.redirect_pc = v.rpc;
    @(posedge clk);
    #1;
    exp_nx = v.e_pc + 32'd4;
    chk({nm, ".req"},   {31'd0, bus.imem_req},    {31'd0, v.e_req});
    chk({nm, ".addr"},  bus.imem_addr,            v.e_pc);
    chk({nm, ".pc"},    bus.pc_current,           v.e_pc);
    chk({nm, ".pcnx"},  bus.pc_next,              exp_nx);
    chk({nm, ".vld"},   {31'd0, bus.instr_valid}, {31'd0, v.e_vld});
    chk({nm, ".instr"}, bus.instruction,          v.e_instr);
    chk({nm, ".fault"}, {31'd0, bus.fetch_fault}, {31'd0, v.e_fault});
  endtask

  vec_t tbl[$];

  initial begin
    bus.imem_ready = 1'b0; bus.imem_rdata = '0; bus.stall = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = '0;
    #2;

    //            rst rdy rdata          stl rdr rpc            req pc             vld instr          flt
    tbl.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 32'h0,          0, 32'h0,          0));
    tbl.push_back(mk(0, 1, 32'h1111_1111,  0, 1, 32'h40,         0, 32'h0,          0, 32'h0,          0));
    tbl.push_back(mk(1, 1, 32'h2222_2222,  0, 1, 32'h40,         1, 32'h0,          0, 32'h0,          0));
    tbl.push_back(mk(1, 1, 32'hA000_0000,  0, 0, 32'h0,          0, 32'h0,          1, 32'hA000_0000,  0));
    tbl.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h4,          0, 32'hA000_0000,  0));
    tbl.push_back(mk(1, 1, 32'hA000_0004,  0, 0, 32'h0,          0, 32'h4,          1, 32'hA000_0004,  0));
    tbl.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'h8,          0, 32'hA000_0004,  0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(1, 0, 32'hFFFF_0000, 0, 0, 32'h0,        1, 32'h8,          0, 32'hA000_0004,  0));
    tbl.push_back(mk(1, 1, 32'hA000_0008,  0, 0, 32'h0,          0, 32'h8,          1, 32'hA000_0008,  0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(1, 1, 32'hDEAD_BEEF, 1, 0, 32'h0,        0, 32'h8,          1, 32'hA000_0008,  0));
    tbl.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 32'hC,          0, 32'hA000_0008,  0));
    tbl.push_back(mk(1, 1, 32'hBAD0_BAD0,  0, 1, 32'h100,        1, 32'h100,        0, 32'hA000_0008,  0));
    tbl.push_back(mk(1, 1, 32'hA000_0100,  0, 0, 32'h0,          0, 32'h100,        1, 32'hA000_0100,  0));
    tbl.push_back(mk(1, 0, 32'h0,          0, 1, 32'h200,        1, 32'h200,        0, 32'hA000_0100,  0));
    tbl.push_back(mk(1, 1, 32'hC000_0200,  0, 0, 32'h0,          0, 32'h200,        1, 32'hC000_0200,  0));
    tbl.push_back(mk(1, 0, 32'h0,          1, 1, 32'h300,        1, 32'h300,        0, 32'hC000_0200,  0));
    tbl.push_back(mk(1, 0, 32'h0,          0, 1, 32'h102,        0, 32'h300,        0, 32'hC000_0200,  1));
    tbl.push_back(mk(1, 1, 32'h1234_5678,  0, 1, 32'h400,        0, 32'h300,        0, 32'hC000_0200,  1));
    tbl.push_back(mk(1, 1, 32'h1234_5678,  0, 0, 32'h0,          0, 32'h300,        0, 32'hC000_0200,  1));

    foreach (tbl[i]) step(tbl[i], $sformatf("v%0d", i));

    // Reset out of FAULT, then PC wrap across 2^32.
    step(mk(0, 0, 32'h0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,         0), "flt_rst");
    step(mk(1, 0, 32'h0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,         0), "wrap_boot");
    step(mk(1, 0, 32'h0, 0, 1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFFC,  0, 32'h0,         0), "wrap_redir");
    step(mk(1, 1, 32'hEEEE_0000, 0, 0, 32'h0,  0, 32'hFFFF_FFFC,  1, 32'hEEEE_0000, 0), "wrap_hold");
    step(mk(1, 0, 32'h0, 0, 0, 32'h0,          1, 32'h0,          0, 32'hEEEE_0000, 0), "wrap_acc");

    // Reset mid-FETCH with a completion pending, then mid-HOLD.
    step(mk(0, 1, 32'h5555_5555, 0, 0, 32'h0,  0, 32'h0,          0, 32'h0,         0), "rst_fetch");
    step(mk(1, 0, 32'h0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,         0), "rf_boot");
    step(mk(1, 1, 32'h7777_7777, 0, 0, 32'h0,  0, 32'h0,          1, 32'h7777_7777, 0), "rf_hold");
    step(mk(0, 0, 32'h0, 1, 0, 32'h0,          0, 32'h0,          0, 32'h0,         0), "rst_hold");
    step(mk(1, 0, 32'h0, 0, 0, 32'h0,          1, 32'h0,          0, 32'h0,         0), "to_boot");

`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 3; i++)
      step(mk(1, 0, 32'h0, 0, 0, 32'h0,        1, 32'h0,          0, 32'h0,         0), $sformatf("to_wait%0d", i));
    step(mk(1, 0, 32'h0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0,         1), "to_fault");
`else
    for (int i = 0; i < 100; i++)
      step(mk(1, 0, 32'h0, 0, 0, 32'h0,        1, 32'h0,          0, 32'h0,         0), $sformatf("nto%0d", i));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the instruction-fetch stage. Owns the program counter, drives a variable-latency instruction-memory request/ready handshake, holds each fetched instruction until decode accepts it, and applies branch/jump redirects. Sits between the instruction memory and the decode stage, replacing free-running PC advance with a handshake-driven state machine.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- TIMEOUT, 16, consecutive unready fetch cycles before fault (1..255, 8-bit counter)

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32  fetch address; always equals pc_current
- imem_ready  in  1  memory completes transfer this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word, valid when imem_req && imem_ready
- stall  in  1  decode cannot accept this cycle
- redirect  in  1  branch/jump taken; load redirect_pc
- redirect_pc  in  32  redirect target
- instr_valid  out  1  instruction/pc_current valid for decode
- instruction  out  32  registered instruction word
- pc_current  out  32  address of the current fetch/held instruction
- pc_next  out  32  pc_current + 4, combinational, wraps mod 2^32
- fetch_fault  out  1  sticky fault flag

## Operation
- States: BOOT, FETCH, HOLD, FAULT.
- Reset (reset=0 at a clk edge): state=BOOT, pc=RESET_PC, imem_req=0, instr_valid=0, instruction=0, fetch_fault=0, wait_cnt=0; pc_next=RESET_PC+4.
- BOOT: exactly one cycle, outputs idle; -> FETCH.
- FETCH: imem_req=1. On imem_ready: instruction<=imem_rdata, instr_valid<=1, wait_cnt<=0, -> HOLD. Otherwise wait_cnt increments.
- HOLD: imem_req=0, instr_valid=1, instruction stable. Accept = instr_valid && !stall. On accept: pc<=pc+4, instr_valid<=0, -> FETCH. While stall=1: stay, all outputs unchanged.
- Redirect (FETCH or HOLD, highest priority): pc<=redirect_pc, instr_valid<=0, wait_cnt<=0, -> FETCH; a same-cycle imem_ready completion and a same-cycle accept are discarded (no pc+4).
- redirect in BOOT is ignored; redirect/stall/imem_ready are ignored in FAULT.
- Misaligned redirect (redirect_pc[1:0]!=0): -> FAULT instead of FETCH; pc unchanged.
- FAULT: imem_req=0, instr_valid=0, fetch_fault=1; exits only via reset.
- Priority per cycle: reset > misaligned redirect > redirect > timeout > imem_ready / accept.

## Timing
- Reset to first imem_req: 1 cycle (BOOT) after reset deasserts.
- Memory latency: imem_ready in the k-th FETCH cycle (k≥1) -> instr_valid=1 on the following cycle.
- Peak throughput: one instruction per 2 cycles (zero-wait memory, no stall).
- Redirect asserted at edge n -> imem_addr=redirect_pc and imem_req=1 from cycle n+1.
- Timeout: FAULT entered at the edge ending the TIMEOUT-th consecutive FETCH cycle with imem_ready=0.
- pc wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no fault.
- Reset mid-FETCH/HOLD: next cycle fully at reset values; in-flight transfer abandoned.

## Configuration
- FETCH_TIMEOUT_EN defined: wait_cnt and TIMEOUT fault active as above.
- Not defined: no counter; FETCH waits indefinitely; fetch_fault set only by misaligned redirect; TIMEOUT parameter unused.

## Test plan
- Reset, imem_ready tied 1, stall=0, memory returns addr-tagged words -> pc_current 0,4,8,… ; instr_valid every 2nd cycle; first instr_valid 3 cycles after reset release.
- imem_ready delayed 3 cycles per fetch -> instr_valid 1 cycle after ready; imem_addr stable throughout wait.
- stall held 5 cycles in HOLD -> instruction, pc_current, instr_valid unchanged; pc advances by 4 only after stall drops.
- redirect_pc=32'h0000_0100 in same cycle as imem_ready -> data discarded, next imem_addr=0x100, no instr_valid for old PC.
- redirect_pc=32'h0000_0102 -> fetch_fault=1, imem_req=0 until reset; reset clears to RESET_PC.
- With FETCH_TIMEOUT_EN, TIMEOUT=4, imem_ready=0 -> fetch_fault rises after 4 FETCH cycles; without macro, no fault after 100 cycles.
